// File: rtl/ysyx_210247_mem_stage_pkg.sv
// Shared types for the MEM pipeline stage.
//   ex_to_mem_t : EX/MEM register contents consumed by the stage
//   mem_to_wb_t : bus presented to the MEM/WB register
//   mem_size_e  : access size encoding (B/H/W/D)
//   state_e     : transaction state of the stage
package ysyx_210247_mem_stage_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] alu_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] wb_data;
  } mem_to_wb_t;

  localparam int EX_TO_MEM_W = $bits(ex_to_mem_t);
  localparam int MEM_TO_WB_W = $bits(mem_to_wb_t);

  // Byte-strobe pattern for an access of the given size at lane 0.
  function automatic logic [7:0] strb_base(input logic [1:0] size);
    case (mem_size_e'(size))
      SZ_B:    strb_base = 8'h01;
      SZ_H:    strb_base = 8'h03;
      SZ_W:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_210247_mem_align.sv
// Combinational load extract/extend and store lane placement.
//   off         : addr[2:0], byte offset within the doubleword
//   size        : access size (mem_size_e encoding)
//   is_unsigned : zero-extend loads (ignored for D)
//   rdata       : aligned 64-bit read doubleword
//   wdata       : store data in its low bits
//   load_data   : extracted and extended load value
//   store_data  : store data replicated and shifted into its lanes
//   store_strb  : byte strobes for the store
module ysyx_210247_mem_align
  import ysyx_210247_mem_stage_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data,
  output logic [7:0]  store_strb
);

  logic [5:0]  shamt;
  logic [63:0] field;
  logic [63:0] lanes;

  assign shamt = {off, 3'b000};
  assign field = rdata >> shamt;

  // NOTE: every output of this block is given a value on every path through
  // the case statements, so no latch is inferred.
  always_comb begin
    case (mem_size_e'(size))
      SZ_B: begin
        load_data = is_unsigned ? {56'd0, field[7:0]}  : {{56{field[7]}},  field[7:0]};
        lanes     = {8{wdata[7:0]}};
      end
      SZ_H: begin
        load_data = is_unsigned ? {48'd0, field[15:0]} : {{48{field[15]}}, field[15:0]};
        lanes     = {4{wdata[15:0]}};
      end
      SZ_W: begin
        load_data = is_unsigned ? {32'd0, field[31:0]} : {{32{field[31]}}, field[31:0]};
        lanes     = {2{wdata[31:0]}};
      end
      default: begin
        load_data = field;
        lanes     = wdata;
      end
    endcase
  end

  // Accesses are naturally aligned, so shifting the replicated pattern puts
  // the data exactly in the strobed lanes.
  assign store_data = lanes << shamt;
  assign store_strb = strb_base(size) << off;

endmodule

// File: rtl/ysyx_210247_mem_stage.sv
// MEM pipeline stage. Non-memory instructions pass straight through; loads
// and stores issue one request on the data-memory port, wait for the
// response, then present a result to MEM/WB with valid/allow handshaking.
// A flush while a request is outstanding without its response parks the
// stage in DRAIN until the orphan response arrives.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : kills the in-stage instruction
//   mem_valid_in        : EX/MEM holds a valid instruction
//   ex_to_mem_bus_i     : EX/MEM register contents
//   mem_allow_in        : stage can accept/retire its input
//   mem_valid_out       : result valid toward MEM/WB
//   mem_to_wb_bus_o     : result bus toward MEM/WB
//   mem_allow_out       : MEM/WB accepts this cycle
//   dmem_req_*          : request channel (valid/ready)
//   dmem_resp_*         : response channel (always accepted)
module ysyx_210247_mem_stage
  import ysyx_210247_mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid_in,
  input  ex_to_mem_t        ex_to_mem_bus_i,
  output logic              mem_allow_in,
  output logic              mem_valid_out,
  output mem_to_wb_t        mem_to_wb_bus_o,
  input  logic              mem_allow_out,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wen,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [1:0]        dmem_req_size,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [7:0]        dmem_req_wstrb,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_resp_rdata
);

  state_e      state;
  state_e      state_next;
  logic [63:0] result;
  logic        capture;
  logic        is_mem;
  logic        is_store;
  logic [63:0] load_data;
  logic [63:0] store_data;
  logic [7:0]  store_strb;

  assign is_mem   = ex_to_mem_bus_i.mem_ren | ex_to_mem_bus_i.mem_wen;
  // A load takes priority if both enables are (illegally) set.
  assign is_store = ex_to_mem_bus_i.mem_wen & ~ex_to_mem_bus_i.mem_ren;

  ysyx_210247_mem_align u_align (
    .off         (ex_to_mem_bus_i.addr[2:0]),
    .size        (ex_to_mem_bus_i.mem_size),
    .is_unsigned (ex_to_mem_bus_i.mem_unsigned),
    .rdata       (dmem_resp_rdata),
    .wdata       (ex_to_mem_bus_i.wdata),
    .load_data   (load_data),
    .store_data  (store_data),
    .store_strb  (store_strb)
  );

  // Request fields come straight from the EX/MEM register, which is held
  // stable because mem_allow_in stays low for the whole transaction.
  assign dmem_req_wen   = is_store;
  assign dmem_req_addr  = ex_to_mem_bus_i.addr;
  assign dmem_req_size  = ex_to_mem_bus_i.mem_size;
  assign dmem_req_wdata = store_data;
  assign dmem_req_wstrb = is_store ? store_strb : 8'h00;

  always_comb begin
    state_next     = state;
    capture        = 1'b0;
    dmem_req_valid = 1'b0;
    mem_valid_out  = 1'b0;
    mem_allow_in   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid_in && is_mem) begin
          if (!flush) begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) state_next = ST_WAIT;
          end
        end else begin
          mem_valid_out = mem_valid_in & ~flush;
          mem_allow_in  = ~mem_valid_in | mem_allow_out;
        end
      end
      ST_WAIT: begin
        if (dmem_resp_valid) begin
          if (flush) begin
            state_next = ST_IDLE;
          end else begin
            capture    = 1'b1;
            state_next = ST_DONE;
          end
        end else if (flush) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        mem_valid_out = ~flush;
        mem_allow_in  = mem_allow_out;
        if (flush || mem_allow_out) state_next = ST_IDLE;
      end
      default: begin
        // The orphan response of a flushed request is swallowed here.
        if (dmem_resp_valid) state_next = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      result <= '0;
    end else begin
      state <= state_next;
      if (capture) result <= ex_to_mem_bus_i.mem_ren ? load_data : 64'd0;
    end
  end

  assign mem_to_wb_bus_o.pc      = ex_to_mem_bus_i.pc;
  assign mem_to_wb_bus_o.inst    = ex_to_mem_bus_i.inst;
  assign mem_to_wb_bus_o.rd      = ex_to_mem_bus_i.rd;
  assign mem_to_wb_bus_o.rd_wen  = ex_to_mem_bus_i.rd_wen;
  assign mem_to_wb_bus_o.wb_data = (state == ST_DONE) ? result : ex_to_mem_bus_i.alu_result;

endmodule

// File: tb/tb_ysyx_210247_mem_stage.sv
// Directed bench for the MEM stage: pass-through, load/store formatting,
// backpressure on both sides, flush in each state and reset mid-transaction.
module tb_ysyx_210247_mem_stage;
  import ysyx_210247_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_valid_in;
  ex_to_mem_t  ex_bus;
  logic        mem_allow_in;
  logic        mem_valid_out;
  mem_to_wb_t  wb_bus;
  logic        mem_allow_out;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_wen;
  logic [63:0] dmem_req_addr;
  logic [1:0]  dmem_req_size;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_210247_mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .mem_valid_in    (mem_valid_in),
    .ex_to_mem_bus_i (ex_bus),
    .mem_allow_in    (mem_allow_in),
    .mem_valid_out   (mem_valid_out),
    .mem_to_wb_bus_o (wb_bus),
    .mem_allow_out   (mem_allow_out),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_wen    (dmem_req_wen),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_size   (dmem_req_size),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wstrb  (dmem_req_wstrb),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic ren, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
    ex_bus.mem_ren      = ren;
    ex_bus.mem_wen      = wen;
    ex_bus.mem_size     = size;
    ex_bus.mem_unsigned = uns;
    ex_bus.addr         = addr;
    ex_bus.wdata        = wdata;
    ex_bus.alu_result   = 64'h5555_5555_5555_5555;
    ex_bus.rd           = 5'd7;
    ex_bus.rd_wen       = 1'b1;
    ex_bus.pc           = 64'h8000_1000;
    mem_valid_in        = 1'b1;
  endtask

  // Minimum-latency transaction: request at T, response T+1, result T+2.
  task automatic mem_txn(input string tag, input logic ren, input logic wen,
                         input logic [1:0] size, input logic uns, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                         input logic [63:0] exp_wb);
    set_mem(ren, wen, size, uns, addr, wdata);
    dmem_req_ready = 1'b1;
    mem_allow_out  = 1'b1;
    #1;
    check({tag, ".req_valid"}, 64'(dmem_req_valid), 64'd1);
    check({tag, ".req_wen"},   64'(dmem_req_wen),   64'(wen));
    check({tag, ".req_addr"},  dmem_req_addr,       addr);
    check({tag, ".req_size"},  64'(dmem_req_size),  64'(size));
    check({tag, ".req_wstrb"}, 64'(dmem_req_wstrb), 64'(exp_strb));
    if (wen) check({tag, ".req_wdata"}, dmem_req_wdata, exp_wdata);
    check({tag, ".allow_in_T"}, 64'(mem_allow_in), 64'd0);
    next_cycle();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = rdata;
    #1;
    check({tag, ".wait_req"},   64'(dmem_req_valid), 64'd0);
    check({tag, ".wait_valid"}, 64'(mem_valid_out),  64'd0);
    next_cycle();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check({tag, ".valid_out"}, 64'(mem_valid_out), 64'd1);
    check({tag, ".wb_data"},   wb_bus.wb_data,     exp_wb);
    check({tag, ".rd_wen"},    64'(wb_bus.rd_wen), 64'd1);
    check({tag, ".allow_in"},  64'(mem_allow_in),  64'd1);
    next_cycle();
    mem_valid_in = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    mem_valid_in    = 1'b0;
    ex_bus          = '0;
    mem_allow_out   = 1'b1;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("reset.valid_out", 64'(mem_valid_out),  64'd0);
    check("reset.req_valid", 64'(dmem_req_valid), 64'd0);
    check("reset.allow_in",  64'(mem_allow_in),   64'd1);

    // ALU pass-through, zero latency.
    next_cycle();
    ex_bus            = '0;
    ex_bus.alu_result = 64'h1234;
    ex_bus.rd_wen     = 1'b1;
    ex_bus.pc         = 64'h8000_0040;
    mem_valid_in      = 1'b1;
    mem_allow_out     = 1'b1;
    #1;
    check("alu.valid_out", 64'(mem_valid_out),  64'd1);
    check("alu.wb_data",   wb_bus.wb_data,      64'h1234);
    check("alu.pc",        wb_bus.pc,           64'h8000_0040);
    check("alu.allow_in",  64'(mem_allow_in),   64'd1);
    check("alu.req_valid", 64'(dmem_req_valid), 64'd0);
    mem_allow_out = 1'b0;
    #1;
    check("alu.stall_allow_in", 64'(mem_allow_in), 64'd0);
    flush = 1'b1;
    #1;
    check("alu.flush_valid", 64'(mem_valid_out), 64'd0);
    flush        = 1'b0;
    mem_valid_in = 1'b0;
    mem_allow_out = 1'b1;

    next_cycle();
    mem_txn("lb_s",  1, 0, 2'd0, 0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
            64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    mem_txn("lbu",   1, 0, 2'd0, 1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
            64'h0, 8'h00, 64'h80);
    mem_txn("lw_s",  1, 0, 2'd2, 0, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF_1234_5678,
            64'h0, 8'h00, 64'hFFFF_FFFF_DEAD_BEEF);
    mem_txn("lh_s",  1, 0, 2'd1, 0, 64'h8000_0002, 64'h0, 64'h1122_3344_5566_7788,
            64'h0, 8'h00, 64'h5566);
    mem_txn("ld",    1, 0, 2'd3, 1, 64'h8000_0008, 64'h0, 64'h8877_6655_4433_2211,
            64'h0, 8'h00, 64'h8877_6655_4433_2211);
    mem_txn("sh",    0, 1, 2'd1, 0, 64'h8000_0006, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hBEEF_0000_0000_0000, 8'hC0, 64'h0);
    mem_txn("sb",    0, 1, 2'd0, 0, 64'h8000_0005, 64'hAB, 64'h0,
            64'hABAB_AB00_0000_0000, 8'h20, 64'h0);
    mem_txn("sw",    0, 1, 2'd2, 0, 64'h8000_0004, 64'h1122_3344, 64'h0,
            64'h1122_3344_0000_0000, 8'hF0, 64'h0);

    // Backpressure: request stalled 3 cycles, result stalled 2 cycles.
    set_mem(1, 0, 2'd2, 1, 64'h8000_0010, 64'h0);
    dmem_req_ready = 1'b0;
    mem_allow_out  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.req_valid", 64'(dmem_req_valid), 64'd1);
      check("bp.req_addr",  dmem_req_addr,       64'h8000_0010);
      check("bp.allow_in",  64'(mem_allow_in),   64'd0);
      next_cycle();
    end
    dmem_req_ready = 1'b1;
    #1;
    check("bp.req_accept", 64'(dmem_req_valid), 64'd1);
    next_cycle();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'h0000_0000_CAFE_F00D;
    next_cycle();
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp.hold_valid",    64'(mem_valid_out), 64'd1);
      check("bp.hold_wb",       wb_bus.wb_data,     64'hCAFE_F00D);
      check("bp.hold_allow_in", 64'(mem_allow_in),  64'd0);
      check("bp.hold_req",      64'(dmem_req_valid), 64'd0);
      next_cycle();
    end
    mem_allow_out = 1'b1;
    #1;
    check("bp.release_valid",    64'(mem_valid_out), 64'd1);
    check("bp.release_allow_in", 64'(mem_allow_in),  64'd1);
    next_cycle();
    mem_valid_in = 1'b0;

    // Flush in WAIT without response -> DRAIN; orphan response must not leak.
    set_mem(1, 0, 2'd3, 0, 64'h8000_0020, 64'h0);
    dmem_req_ready = 1'b1;
    next_cycle();
    dmem_req_ready = 1'b0;
    flush          = 1'b1;
    mem_valid_in   = 1'b0;
    #1;
    check("fw.t1_valid", 64'(mem_valid_out), 64'd0);
    next_cycle();
    flush = 1'b0;
    set_mem(1, 0, 2'd3, 0, 64'h8000_0028, 64'h0);
    #1;
    check("fw.drain_req",      64'(dmem_req_valid), 64'd0);
    check("fw.drain_allow_in", 64'(mem_allow_in),   64'd0);
    check("fw.drain_valid",    64'(mem_valid_out),  64'd0);
    next_cycle();
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    check("fw.orphan_req",   64'(dmem_req_valid), 64'd0);
    check("fw.orphan_valid", 64'(mem_valid_out),  64'd0);
    next_cycle();
    dmem_resp_valid = 1'b0;
    mem_txn("fw.new_ld", 1, 0, 2'd3, 0, 64'h8000_0028, 64'h0, 64'h0123_4567_89AB_CDEF,
            64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);

    // Flush in WAIT together with the response: dropped, back to IDLE.
    set_mem(1, 0, 2'd3, 0, 64'h8000_0030, 64'h0);
    dmem_req_ready = 1'b1;
    next_cycle();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    flush           = 1'b1;
    #1;
    check("fwr.valid", 64'(mem_valid_out), 64'd0);
    next_cycle();
    dmem_resp_valid = 1'b0;
    flush           = 1'b0;
    mem_valid_in    = 1'b0;
    #1;
    check("fwr.idle_valid",    64'(mem_valid_out), 64'd0);
    check("fwr.idle_allow_in", 64'(mem_allow_in),  64'd1);
    mem_valid_in = 1'b1;
    #1;
    check("fwr.reissue", 64'(dmem_req_valid), 64'd1);
    next_cycle();
    mem_valid_in = 1'b0;

    // Flush in IDLE with a memory instruction: no request that cycle.
    set_mem(0, 1, 2'd3, 0, 64'h8000_0038, 64'h1);
    dmem_req_ready = 1'b1;
    flush          = 1'b1;
    #1;
    check("fi.req_valid", 64'(dmem_req_valid), 64'd0);
    next_cycle();
    flush          = 1'b0;
    dmem_req_ready = 1'b0;
    #1;
    check("fi.still_idle", 64'(dmem_req_valid), 64'd1);
    next_cycle();
    mem_valid_in = 1'b0;

    // Flush in DONE while MEM/WB stalls.
    set_mem(1, 0, 2'd0, 1, 64'h8000_0001, 64'h0);
    dmem_req_ready = 1'b1;
    mem_allow_out  = 1'b0;
    next_cycle();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'h0000_0000_0000_5A00;
    next_cycle();
    dmem_resp_valid = 1'b0;
    #1;
    check("fd.done_valid", 64'(mem_valid_out), 64'd1);
    check("fd.done_wb",    wb_bus.wb_data,     64'h5A);
    next_cycle();
    flush = 1'b1;
    #1;
    check("fd.flush_valid", 64'(mem_valid_out), 64'd0);
    next_cycle();
    flush        = 1'b0;
    mem_valid_in = 1'b0;
    #1;
    check("fd.idle_valid",    64'(mem_valid_out), 64'd0);
    check("fd.idle_allow_in", 64'(mem_allow_in),  64'd1);
    mem_allow_out = 1'b1;

    // Reset while in WAIT.
    next_cycle();
    set_mem(1, 0, 2'd3, 0, 64'h8000_0040, 64'h0);
    dmem_req_ready = 1'b1;
    next_cycle();
    dmem_req_ready = 1'b0;
    rst            = 1'b1;
    #1;
    check("rw.wait_req", 64'(dmem_req_valid), 64'd0);
    next_cycle();
    rst          = 1'b0;
    mem_valid_in = 1'b0;
    #1;
    check("rw.valid_out", 64'(mem_valid_out),  64'd0);
    check("rw.req_valid", 64'(dmem_req_valid), 64'd0);
    check("rw.allow_in",  64'(mem_allow_in),   64'd1);
    mem_valid_in = 1'b1;
    #1;
    check("rw.idle_issue", 64'(dmem_req_valid), 64'd1);
    next_cycle();
    mem_valid_in = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
